alu_seq: RTL and testbench

- Registered, parametrised-width ALU with a start/ready/done handshake.
- Performs add/subtract with optional carry chaining, NOR, load, lossless shifts, and a multi-cycle unsigned shift-add multiply.
- Holds carry and zero flags in registers between operations.
- Sits between the register file and the datapath result bus; the control unit issues one operation at a time and waits for `done`.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_mul_seq.sv | 50 +++++
 rtl/alu_seq.sv | 117 +++++++++++
 tb/tb_alu_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NOR  = 3'b010,
    OP_LOAD = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_MUL  = 3'b110,
    OP_NOP  = 3'b111
  } alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle, WIDTH cycles total.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 last_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic [WIDTH:0]     hi_sum;

  // Low half of acc starts as the multiplier and is consumed from bit 0 as the
  // partial product shifts in from the top.
  assign hi_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  // Next accumulator value; on the last iteration this is the final product.
  assign product_o = {hi_sum, acc_q[WIDTH-1:1]};
  assign last_o    = busy_q && (cnt_q == LAST_CNT);
  assign busy_o    = busy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (load_i) begin
      mcand_q <= a_i;
      acc_q   <= {{WIDTH{1'b0}}, b_i};
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      acc_q <= product_o;
      cnt_q <= cnt_q + CW'(1);
      if (last_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/ready/done handshake; single-cycle ops complete in
// IDLE, MUL hands off to the shift-add sub-block for WIDTH cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic             use_carry_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             cout_o,
  output logic             zout_o
);

  alu_state_t         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d, result_hi_q, result_hi_d;
  logic               cout_q, cout_d, zout_q, zout_d, done_q, done_d;
  logic               mul_load, mul_busy, mul_last;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     add_sum, sub_diff;
  logic               cin;
  alu_op_t            op;

  assign op       = alu_op_t'(op_i);
  assign cin      = use_carry_i & cout_q;
  assign add_sum  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin};
  // Top bit of the widened difference is the borrow out.
  assign sub_diff = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin};

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (mul_load),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (mul_busy),
    .product_o(mul_prod),
    .last_o   (mul_last)
  );

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    cout_d      = cout_q;
    zout_d      = zout_q;
    done_d      = 1'b0;
    mul_load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && op == OP_MUL) begin
          mul_load = 1'b1;
          state_d  = ST_MUL;
        end else if (start_i) begin
          done_d = 1'b1;
          case (op)
            OP_ADD:  {cout_d, result_d} = add_sum;
            OP_SUB:  {cout_d, result_d} = sub_diff;
            OP_NOR:  begin result_d = ~(a_i | b_i); cout_d = 1'b0; end
            OP_LOAD: result_d = a_i;
            OP_SHL:  begin result_d = {a_i[WIDTH-2:0], 1'b0}; cout_d = a_i[WIDTH-1]; end
            OP_SHR:  begin result_d = {1'b0, a_i[WIDTH-1:1]}; cout_d = a_i[0]; end
            default: ;
          endcase
          if (op != OP_NOP) begin
            result_hi_d = '0;
            zout_d      = (result_d == '0);
          end
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          result_d    = mul_prod[WIDTH-1:0];
          result_hi_d = mul_prod[2*WIDTH-1:WIDTH];
          cout_d      = |mul_prod[2*WIDTH-1:WIDTH];
          zout_d      = (mul_prod == '0);
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      cout_q      <= 1'b0;
      zout_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      cout_q      <= cout_d;
      zout_q      <= zout_d;
      done_q      <= done_d;
    end
  end

  assign ready_o     = (state_q == ST_IDLE) && !mul_busy;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign result_hi_o = result_hi_q;
  assign cout_o      = cout_q;
  assign zout_o      = zout_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases plus random ops checked against an
// arithmetic reference model of the ALU's visible state.
module tb_alu_seq;

  localparam int W = 8;
  localparam int MOD = 1 << W;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [2:0]   op_i = '0;
  logic         use_carry_i = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         ready_o, done_o, cout_o, zout_o;
  logic [W-1:0] result_o, result_hi_o;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [W-1:0] m_res = '0, m_hi = '0;
  logic         m_cout = 1'b0, m_z = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .use_carry_i(use_carry_i), .a_i(a_i), .b_i(b_i), .ready_o(ready_o),
    .done_o(done_o), .result_o(result_o), .result_hi_o(result_hi_o),
    .cout_o(cout_o), .zout_o(zout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_apply(input logic [2:0] op, input logic uc,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    int av, bv, c, s;
    av = int'(a); bv = int'(b);
    c  = (uc && m_cout) ? 1 : 0;
    case (op)
      3'd0: begin s = av + bv + c; m_cout = (s >= MOD); m_res = W'(s % MOD); end
      3'd1: begin s = av - bv - c; m_cout = (s < 0); m_res = W'((s + 2 * MOD) % MOD); end
      3'd2: begin m_res = ~(a | b); m_cout = 1'b0; end
      3'd3: m_res = a;
      3'd4: begin m_cout = (av >= MOD / 2); m_res = W'((av * 2) % MOD); end
      3'd5: begin m_cout = (av % 2) == 1; m_res = W'(av / 2); end
      3'd6: begin s = av * bv; m_res = W'(s % MOD); m_hi = W'(s / MOD); m_cout = (s >= MOD); m_z = (s == 0); end
      default: ;
    endcase
    if (op <= 3'd5) begin
      m_hi = '0;
      m_z  = (m_res == '0);
    end
  endtask

  task automatic check_outputs(input string nm);
    total++; if (result_o !== m_res) begin bad++; $display("FAIL %s result got=%h exp=%h", nm, result_o, m_res); end
    total++; if (result_hi_o !== m_hi) begin bad++; $display("FAIL %s result_hi got=%h exp=%h", nm, result_hi_o, m_hi); end
    total++; if (cout_o !== m_cout) begin bad++; $display("FAIL %s cout got=%b exp=%b", nm, cout_o, m_cout); end
    total++; if (zout_o !== m_z) begin bad++; $display("FAIL %s zout got=%b exp=%b", nm, zout_o, m_z); end
  endtask

  // Issue one op, wait for completion, compare, then confirm done drops.
  task automatic run_op(input logic [2:0] op, input logic uc,
                        input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
    int cnt;
    model_apply(op, uc, a, b);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; use_carry_i = uc; a_i = a; b_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    if (op != 3'd6) begin
      total++; if (done_o !== 1'b1) begin bad++; $display("FAIL %s done got=%b exp=1", nm, done_o); end
    end else begin
      total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL %s ready_at_accept got=%b exp=0", nm, ready_o); end
      cnt = 0;
      forever begin
        @(negedge clk_i);
        start_i = (cnt == 3);
        if (cnt == 3) begin op_i = 3'd0; a_i = W'($urandom); b_i = W'($urandom); end
        @(posedge clk_i); #1;
        cnt++;
        if (done_o === 1'b1) break;
        if (cnt > W + 4) break;
      end
      start_i = 1'b0;
      total++; if (cnt !== W) begin bad++; $display("FAIL %s mul_latency got=%0d exp=%0d", nm, cnt, W); end
      total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL %s ready_at_done got=%b exp=1", nm, ready_o); end
    end
    check_outputs(nm);
    @(posedge clk_i); #1;
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL %s done_pulse got=%b exp=0", nm, done_o); end
  endtask

  task automatic test_reset;
    #2;
    total++; if ({ready_o, done_o, result_o, result_hi_o, cout_o, zout_o} !== {1'b1, 1'b0, {2*W{1'b0}}, 2'b00})
      begin bad++; $display("FAIL reset got=%b%b %h %h %b%b exp=10 00 00 00", ready_o, done_o, result_o, result_hi_o, cout_o, zout_o); end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;
    total++; if (done_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL post_reset done=%b ready=%b exp=0/1", done_o, ready_o); end
  endtask

  task automatic test_directed;
    run_op(3'd0, 1'b0, 8'hFF, 8'h01, "add_ff_01");
    run_op(3'd0, 1'b1, 8'h10, 8'h20, "add_carry_chain");
    total++; if (result_o !== 8'h31) begin bad++; $display("FAIL add_chain_const got=%h exp=31", result_o); end
    run_op(3'd1, 1'b0, 8'h05, 8'h07, "sub_borrow");
    run_op(3'd5, 1'b0, 8'h03, 8'h00, "shr");
    run_op(3'd4, 1'b0, 8'h80, 8'h00, "shl");
    run_op(3'd2, 1'b0, 8'h0F, 8'hA0, "nor");
    run_op(3'd3, 1'b1, 8'h00, 8'h55, "load_zero");
    run_op(3'd6, 1'b0, 8'hFF, 8'hFF, "mul_ff_ff");
    total++; if ({result_hi_o, result_o} !== 16'hFE01) begin bad++; $display("FAIL mul_const got=%h exp=fe01", {result_hi_o, result_o}); end
    run_op(3'd6, 1'b0, 8'h00, 8'h37, "mul_zero");
    run_op(3'd7, 1'b1, 8'h9A, 8'hBC, "nop");
    run_op(3'd1, 1'b1, 8'h00, 8'h00, "sub_chain_zero");
  endtask

  task automatic test_random;
    logic [2:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      run_op(op, 1'($urandom), W'($urandom), W'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] op;
    logic uc;
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 6));
      if (op == 3'd6) op = 3'd7;
      uc = 1'($urandom); a = W'($urandom); b = W'($urandom);
      model_apply(op, uc, a, b);
      @(negedge clk_i);
      start_i = 1'b1; op_i = op; use_carry_i = uc; a_i = a; b_i = b;
      @(posedge clk_i); #1;
      total++; if (done_o !== 1'b1) begin bad++; $display("FAIL b2b done got=%b exp=1", done_o); end
      check_outputs("b2b");
    end
    @(negedge clk_i); start_i = 1'b0;
  endtask

  task automatic test_rst_mid_mul;
    run_op(3'd3, 1'b0, 8'hA5, 8'h00, "load_pre_rst");
    @(negedge clk_i);
    start_i = 1'b1; op_i = 3'd6; a_i = 8'h12; b_i = 8'h34;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1; rst_i = 1'b1; #1;
    total++; if ({ready_o, done_o, result_o, result_hi_o, cout_o, zout_o} !== {1'b1, 1'b0, {2*W{1'b0}}, 2'b00})
      begin bad++; $display("FAIL rst_mid_mul got=%b%b %h %h %b%b exp=10 00 00 00", ready_o, done_o, result_o, result_hi_o, cout_o, zout_o); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); #1;
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL rst_no_done got=%b exp=0", done_o); end
    end
    m_res = '0; m_hi = '0; m_cout = 1'b0; m_z = 1'b0;
    model_apply(3'd0, 1'b1, 8'h12, 8'h34);
    @(negedge clk_i);
    rst_i = 1'b0;
    start_i = 1'b1; op_i = 3'd0; use_carry_i = 1'b1; a_i = 8'h12; b_i = 8'h34;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL post_rst_add done got=%b exp=1", done_o); end
    check_outputs("post_rst_add");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_rst_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
